// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, queue entry layout,
// and the instruction size used to step the PC.
package fetch_ctrl_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_queue.sv
// Small circular fetch queue; head entry is visible combinationally, no output register.
// Push and pop may both happen in one cycle, including when full; flush wins over both.
module fetch_queue
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head_entry,
  output logic [CW-1:0] count
);

  fetch_entry_t    store [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  assign head_entry = store[head];

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        store[tail] <= push_entry;
        tail        <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC, FETCH/HALT FSM and redirect handling feeding a fetch queue.
// An instruction fetched at edge N appears on out_* in cycle N+1; one per cycle when out_ready stays high.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FQ_DEPTH   = 2,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [CW-1:0] count;
  fetch_entry_t  head_entry;
  fetch_entry_t  new_entry;
  logic          in_range;
  logic          room;
  logic          enq;
  logic          deq;

  assign imem_addr = {2'b00, pc[31:2]};
  assign in_range  = imem_addr < 32'(IMEM_WORDS);
  assign out_valid = (count != '0);
  assign out_inst  = head_entry.inst;
  assign out_pc    = head_entry.pc;
  assign halted    = (state == HALT);

  // A full queue can still accept when the head leaves in the same cycle.
  assign room = (count < CW'(FQ_DEPTH)) || (out_valid && out_ready);
  assign enq  = (state == FETCH) && !redirect_valid && in_range && room;
  assign deq  = out_valid && out_ready && !redirect_valid;

  assign new_entry.inst = imem_inst;
  assign new_entry.pc   = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC & ~32'd3;
    end else if (redirect_valid) begin
      state <= FETCH;
      pc    <= redirect_pc & ~32'd3;
    end else if (state == FETCH && !in_range) begin
      state <= HALT;
    end else if (enq) begin
      pc <= pc + 32'(INST_BYTES);
    end
  end

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (enq),
    .push_entry(new_entry),
    .pop       (deq),
    .head_entry(head_entry),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fetch_ctrl;

  localparam int DEPTH = 2;
  localparam int WORDS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;

  logic [31:0] mem [WORDS];

  // Reference model: list of {inst, pc} awaiting consumption, plus PC and halt flag.
  logic [63:0] m_q [$];
  logic [31:0] m_pc;
  bit          m_halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb imem_inst = (imem_addr < WORDS) ? mem[imem_addr[3:0]] : 32'hDEAD_BEEF;

  fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .FQ_DEPTH  (DEPTH),
    .IMEM_WORDS(WORDS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .halted        (halted)
  );

  task automatic model_reset();
    m_q.delete();
    m_pc = 32'h0;
    m_halted = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs mid-cycle, advance the model, return just after the edge.
  task automatic drive_cycle(input bit rv, input logic [31:0] rp, input bit rdy);
    bit take;
    bit room;
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc = rp;
    out_ready = rdy;
    if (rv) begin
      m_q.delete();
      m_pc = rp & ~32'd3;
      m_halted = 1'b0;
    end else begin
      take = rdy && (m_q.size() > 0);
      room = (m_q.size() < DEPTH) || take;
      if (take) void'(m_q.pop_front());
      if (!m_halted) begin
        if ((m_pc >> 2) >= WORDS) m_halted = 1'b1;
        else if (room) begin
          m_q.push_back({mem[m_pc[5:2]], m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL reset_out: got pc %h inst %h want 0 0", out_pc, out_inst); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    drive_cycle(1'b0, 32'h0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h003100B3) begin
      errors++; $display("FAIL first_fetch0: got v%b pc %h inst %h want v1 pc 0 inst 003100b3", out_valid, out_pc, out_inst); end
    drive_cycle(1'b0, 32'h0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_inst !== 32'h001080B3) begin
      errors++; $display("FAIL first_fetch1: got v%b pc %h inst %h want v1 pc 4 inst 001080b3", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b0);
      checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: got v%b pc %h want v1 pc 0", out_valid, out_pc); end
    end
    checks++; if (imem_addr !== 32'h2) begin errors++; $display("FAIL stall_pc: got addr %h want 2", imem_addr); end
    for (int i = 1; i <= 2; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin
        errors++; $display("FAIL stall_order: got v%b pc %h want v1 pc %h", out_valid, out_pc, 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive_cycle(1'b0, 32'h0, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b0);
    drive_cycle(1'b1, 32'h23, 1'b1);
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL redirect_flush: got v%b addr %h want v0 addr 8", out_valid, imem_addr); end
    drive_cycle(1'b0, 32'h0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_inst !== mem[8]) begin
      errors++; $display("FAIL redirect_target: got v%b pc %h inst %h want v1 pc 20 inst %h", out_valid, out_pc, out_inst, mem[8]); end
  endtask

  task automatic test_halt();
    int n;
    drive_cycle(1'b1, 32'h30, 1'b1);
    n = 0;
    while (!halted && n < 20) begin drive_cycle(1'b0, 32'h0, 1'b1); n++; end
    checks++; if (halted !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL halt_enter: got halted %b addr %h want 1 10", halted, imem_addr); end
    n = 0;
    while (out_valid && n < 5) begin drive_cycle(1'b0, 32'h0, 1'b1); n++; end
    checks++; if (out_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL halt_drain: got v%b halted %b addr %h want v0 1 10", out_valid, halted, imem_addr); end
    drive_cycle(1'b0, 32'h0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_noenq: got v%b want 0", out_valid); end
    drive_cycle(1'b1, 32'h0, 1'b0);
    checks++; if (halted !== 1'b0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL halt_clear: got halted %b addr %h want 0 0", halted, imem_addr); end
    drive_cycle(1'b0, 32'h0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h003100B3) begin
      errors++; $display("FAIL halt_resume: got v%b pc %h inst %h want v1 0 003100b3", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_cycle(1'b0, 32'h0, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b0);
    checks++; if (out_valid !== 1'b1 || imem_addr !== 32'h2) begin
      errors++; $display("FAIL areset_pre: got v%b addr %h want v1 2", out_valid, imem_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0) begin
      errors++; $display("FAIL areset_now: got v%b addr %h pc %h want v0 0 0", out_valid, imem_addr, out_pc); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive_cycle(1'b0, 32'h0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL areset_restart: got v%b pc %h want v1 0", out_valid, out_pc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    do_reset();
    drive_cycle(1'b0, 32'h0, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b0);
    prev = out_pc;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_pc !== prev + 32'd4 || imem_addr !== (out_pc >> 2) + 32'd2) begin
        errors++; $display("FAIL b2b_step: got v%b pc %h addr %h want v1 pc %h addr %h", out_valid, out_pc, imem_addr, prev + 32'd4, ((prev + 32'd4) >> 2) + 32'd2); end
      prev = prev + 32'd4;
    end
  endtask

  task automatic test_random();
    bit rv;
    bit rdy;
    logic [31:0] rp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 9) == 0);
      rp = 32'($urandom_range(0, 80));
      rdy = ($urandom_range(0, 2) != 0);
      drive_cycle(rv, rp, rdy);
      checks++; if (out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rand_valid: cycle %0d got %b want %b", i, out_valid, m_q.size() != 0); end
      checks++; if (imem_addr !== (m_pc >> 2)) begin errors++; $display("FAIL rand_addr: cycle %0d got %h want %h", i, imem_addr, m_pc >> 2); end
      checks++; if (halted !== m_halted) begin errors++; $display("FAIL rand_halted: cycle %0d got %b want %b", i, halted, m_halted); end
      if (m_q.size() != 0) begin
        checks++; if ({out_inst, out_pc} !== m_q[0]) begin
          errors++; $display("FAIL rand_head: cycle %0d got %h want %h", i, {out_inst, out_pc}, m_q[0]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h003100B3;
    mem[1] = 32'h001080B3;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect();
    test_halt();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 2: fetch-queue entries; legal values are 2 and 4 only.
REQ-003 SHALL have parameter IMEM_WORDS, default 1024: instruction-memory depth in words.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 imem_addr  out  32  word index into instruction memory, equal to {2'b00, pc[31:2]}.
REQ-007 imem_inst  in  32  instruction word; combinational, valid in the same cycle as imem_addr.
REQ-008 redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
REQ-009 redirect_pc  in  32  byte target address; bits [1:0] are ignored and forced to 0.
REQ-010 out_valid  out  1  head queue entry is valid.
REQ-011 out_ready  in  1  consumer accepts the head entry.
REQ-012 out_inst  out  32  instruction word of the head entry.
REQ-013 out_pc  out  32  byte address of the head entry.
REQ-014 halted  out  1  high while the FSM is in HALT.

Function
REQ-015 SHALL hold a 32-bit byte PC whose bits [1:0] are always 0.
- Next PC = pc + 4 on each enqueue.
- Arithmetic wraps modulo 2^32.
REQ-016 FSM SHALL have exactly two states, FETCH and HALT; the reset state is FETCH.
REQ-017 SHALL compute enqueue (enq) as FETCH && !redirect_valid && (count < FQ_DEPTH || (out_valid && out_ready)).
REQ-018 On enq, SHALL write {imem_inst, pc} at the tail, then advance the tail and the PC.
REQ-019 SHALL compute dequeue (deq) as out_valid && out_ready && !redirect_valid.
- On deq, SHALL advance the head.
- out_* SHALL be driven directly from the head entry (no output register).
REQ-020 Simultaneous enq and deq SHALL leave count unchanged; this SHALL be legal when the queue is full.
REQ-021 Head and tail pointers SHALL wrap modulo FQ_DEPTH.
- count SHALL range 0..FQ_DEPTH.
- out_valid = (count != 0).
REQ-022 Fetch latency: an instruction enqueued at edge N SHALL be visible on out_* from cycle N+1.
- Sustained throughput SHALL be one instruction per cycle while out_ready is high.
REQ-023 When pc[31:2] >= IMEM_WORDS and the FSM is in FETCH with no redirect, SHALL move to HALT without enqueuing.
- In HALT, the queue SHALL continue to drain normally.
REQ-024 redirect_valid in any state SHALL have priority over enq and deq. At the next edge:
- count=0 and head=tail=0;
- pc=redirect_pc & ~3;
- state=FETCH.
REQ-025 In the redirect cycle, out_valid SHALL still reflect the old queue, but no handshake SHALL complete in that cycle.
REQ-026 imem_addr SHALL always reflect the current pc, including in HALT.
REQ-027 While out_valid=1 and out_ready=0, out_inst and out_pc SHALL remain stable.

Reset
REQ-028 While rst_n=0, SHALL asynchronously force:
- pc=RESET_PC, so imem_addr=RESET_PC>>2;
- count=0, head=tail=0;
- state=FETCH;
- out_valid=0, halted=0;
- out_inst and out_pc = 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries with no partial handshake.
- The first fetch SHALL occur at the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package SHALL hold:
- the fetch-state enum;
- the fetch-entry struct {inst[31:0], pc[31:0]};
- constant INST_BYTES=4.
REQ-031 The queue SHALL be a separate sub-module, fetch_queue (parameterised depth, push/pop/count, flush input).
- fetch_ctrl SHALL contain the PC, FSM and redirect logic.
REQ-032 SHALL instantiate no memory; it connects externally to the word-indexed instruction memory.

Verification
REQ-033 Reset release, out_ready=1, memory word0=32'h003100B3, word1=32'h001080B3:
- cycle 1: out_valid=1, out_pc=0, out_inst=32'h003100B3;
- cycle 2: out_pc=4, out_inst=32'h001080B3.
REQ-034 out_ready=0 for 5 cycles after reset, FQ_DEPTH=2:
- count saturates at 2 and pc=8;
- out_pc stays 0;
- on raising out_ready, the order is 0, 4, 8 with no gap.
REQ-035 redirect_valid=1 with redirect_pc=32'h0000_0023 while the queue is full:
- next cycle count=0, out_valid=0, pc=32'h20;
- the following cycle out_pc=32'h20, out_inst=word8.
REQ-036 IMEM_WORDS=16, run to pc=0x40:
- halted=1 and no further enqueue;
- the queue drains to out_valid=0;
- redirect to 0 clears halted and fetch resumes at word0.
REQ-037 Assert rst_n=0 asynchronously mid-cycle with count=2:
- out_valid=0 immediately, before the next edge;
- pc returns to RESET_PC.
REQ-038 Simultaneous enq+deq with full queue for 10 cycles: out_pc increments by 4 every cycle and count stays 2.
